// File: rtl/i2c_target_rx.sv
// rtl/i2c_target_rx.sv - I2C target write receiver with address match, ACK drive and byte delivery
// Optional GENERAL_CALL_EN: also ACK the general-call address 8'h00 (o_addr_match stays 0 for it).
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       std_clk,
  input  logic       reset_n,
  input  logic       i_scl,
  input  logic       i_sda,
  input  logic       i_rx_ready,
  output logic       o_sda_oe,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_addr_match,
  output logic       o_busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ADDR     = 3'd1;
  localparam logic [2:0] ADDR_ACK = 3'd2;
  localparam logic [2:0] DATA     = 3'd3;
  localparam logic [2:0] DATA_ACK = 3'd4;
  localparam logic [2:0] IGNORE   = 3'd5;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_h;
  logic sda_h;
  logic [2:0] state;
  logic [3:0] cnt;
  logic [7:0] shift_q;
  logic ack_pending;
  logic gc_q;

  always_ff @(posedge std_clk) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
      scl_h    <= scl_sync[SYNC_STAGES-1];
      sda_h    <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = !scl_h && scl_s;
  assign scl_fall  = scl_h && !scl_s;
  // Requiring SCL high in both samples means an SCL edge always wins over a coincident SDA edge.
  assign start_det = scl_h && scl_s && sda_h && !sda_s;
  assign stop_det  = scl_h && scl_s && !sda_h && sda_s;

  logic [7:0] next_shift;
  logic is_gc, addr_ok;
  assign next_shift = {shift_q[6:0], sda_s};
`ifdef GENERAL_CALL_EN
  assign is_gc = (next_shift == 8'h00);
`else
  assign is_gc = 1'b0;
`endif
  assign addr_ok = (next_shift == {TARGET_ADDR, 1'b0}) || is_gc;

  always_ff @(posedge std_clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      shift_q      <= 8'd0;
      ack_pending  <= 1'b0;
      gc_q         <= 1'b0;
      o_sda_oe     <= 1'b0;
      o_data       <= 8'd0;
      o_data_valid <= 1'b0;
      o_addr_match <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      if (stop_det) begin
        state        <= IDLE;
        cnt          <= 4'd0;
        ack_pending  <= 1'b0;
        o_sda_oe     <= 1'b0;
        o_addr_match <= 1'b0;
        o_busy       <= 1'b0;
      end else if (start_det) begin
        state        <= ADDR;
        cnt          <= 4'd0;
        ack_pending  <= 1'b0;
        o_sda_oe     <= 1'b0;
        o_addr_match <= 1'b0;
        o_busy       <= 1'b1;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && cnt != 4'd8) begin
              shift_q <= next_shift;
              cnt     <= cnt + 4'd1;
              if (cnt == 4'd7) begin
                if (addr_ok) begin
                  ack_pending <= 1'b1;
                  gc_q        <= is_gc;
                end else begin
                  state <= IGNORE;
                end
              end
            end else if (scl_fall && cnt == 4'd8 && ack_pending) begin
              state        <= ADDR_ACK;
              ack_pending  <= 1'b0;
              o_sda_oe     <= 1'b1;
              o_addr_match <= !gc_q;
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              o_sda_oe <= 1'b0;
              state    <= DATA;
              cnt      <= 4'd0;
            end
          end
          DATA: begin
            if (scl_rise && cnt != 4'd8) begin
              shift_q <= next_shift;
              cnt     <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              // Consumer back-pressure is answered with a NACK since SCL is never stretched.
              if (i_rx_ready) begin
                o_sda_oe     <= 1'b1;
                o_data       <= shift_q;
                o_data_valid <= 1'b1;
                state        <= DATA_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb/tb_i2c_target_rx.sv - directed bench acting as I2C controller for i2c_target_rx
module tb_i2c_target_rx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic rx_ready = 1'b1;
  logic sda_oe;
  logic [7:0] data;
  logic data_valid, addr_match, busy;
  logic sda_line;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_rx dut (
    .std_clk(clk), .reset_n(reset_n), .i_scl(scl), .i_sda(sda_line),
    .i_rx_ready(rx_ready), .o_sda_oe(sda_oe), .o_data(data),
    .o_data_valid(data_valid), .o_addr_match(addr_match), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  logic [7:0] data_q[$];
  logic oe_seen = 1'b0;
  logic busy_low = 1'b0;

  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt++;
      data_q.push_back(data);
    end
    if (sda_oe) oe_seen = 1'b1;
    if (!busy) busy_low = 1'b1;
  end

  task automatic wq();
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_mon();
    valid_cnt = 0;
    data_q.delete();
    oe_seen = 1'b0;
    busy_low = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl = 1'b1; wq();
    sda_m = 1'b1; wq(); wq();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; wq();
      scl = 1'b1; wq(); wq();
      scl = 1'b0; wq();
    end
  endtask

  task automatic ack_slot(output logic ack);
    sda_m = 1'b1; wq();
    scl = 1'b1; wq();
    ack = sda_oe;
    wq();
    scl = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    ack_slot(ack);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe got=%b exp=0", sda_oe); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL reset_match got=%b exp=0", addr_match); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_write();
    logic a0, a1;
    clear_mon();
    rx_ready = 1'b1;
    i2c_start();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start got=%b exp=1", busy); end
    send_byte(8'hA0, a0);
    n_checks++; if (addr_match !== 1'b1) begin n_fail++; $display("FAIL basic_match got=%b exp=1", addr_match); end
    send_byte(8'hA5, a1);
    n_checks++; if (a0 !== 1'b1) begin n_fail++; $display("FAIL basic_addr_ack got=%b exp=1", a0); end
    n_checks++; if (a1 !== 1'b1) begin n_fail++; $display("FAIL basic_data_ack got=%b exp=1", a1); end
    i2c_stop();
    n_checks++; if (valid_cnt !== 1) begin n_fail++; $display("FAIL basic_valid_cnt got=%0d exp=1", valid_cnt); end
    n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL basic_data got=%h exp=a5", data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_stop got=%b exp=0", busy); end
    n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL basic_match_stop got=%b exp=0", addr_match); end
  endtask

  task automatic test_wrong_addr();
    logic a;
    clear_mon();
    i2c_start();
    send_byte(8'hA2, a);
    send_byte(8'h3C, a);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wrong_busy got=%b exp=1", busy); end
    i2c_stop();
    n_checks++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL wrong_oe_seen got=%b exp=0", oe_seen); end
    n_checks++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL wrong_valid_cnt got=%0d exp=0", valid_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_busy_stop got=%b exp=0", busy); end
  endtask

  task automatic test_read_addr();
    logic a;
    clear_mon();
    i2c_start();
    send_byte(8'hA1, a);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL read_ack got=%b exp=0", a); end
    send_byte(8'h5A, a);
    n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL read_match got=%b exp=0", addr_match); end
    n_checks++; if (oe_seen !== 1'b0) begin n_fail++; $display("FAIL read_oe_seen got=%b exp=0", oe_seen); end
    i2c_stop();
    n_checks++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL read_valid_cnt got=%0d exp=0", valid_cnt); end
  endtask

  task automatic test_repeated_start();
    logic a;
    clear_mon();
    i2c_start();
    busy_low = 1'b0;
    send_byte(8'hA0, a);
    send_byte(8'h12, a);
    i2c_start();
    n_checks++; if (busy_low !== 1'b0) begin n_fail++; $display("FAIL rs_busy_dropped got=%b exp=0", busy_low); end
    n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL rs_match_cleared got=%b exp=0", addr_match); end
    send_byte(8'hA0, a);
    send_byte(8'h34, a);
    i2c_stop();
    n_checks++; if (valid_cnt !== 2) begin n_fail++; $display("FAIL rs_valid_cnt got=%0d exp=2", valid_cnt); end
    if (data_q.size() == 2) begin
      n_checks++; if (data_q[0] !== 8'h12) begin n_fail++; $display("FAIL rs_data0 got=%h exp=12", data_q[0]); end
      n_checks++; if (data_q[1] !== 8'h34) begin n_fail++; $display("FAIL rs_data1 got=%h exp=34", data_q[1]); end
    end
  endtask

  task automatic test_partial_and_nack();
    logic a;
    clear_mon();
    i2c_start();
    send_byte(8'hA0, a);
    send_bits(8'hF0, 4);
    i2c_stop();
    n_checks++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL partial_valid_cnt got=%0d exp=0", valid_cnt); end
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL partial_oe got=%b exp=0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL partial_busy got=%b exp=0", busy); end
    clear_mon();
    rx_ready = 1'b0;
    i2c_start();
    send_byte(8'hA0, a);
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL nack_addr_ack got=%b exp=1", a); end
    send_byte(8'h77, a);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL nack_data_ack got=%b exp=0", a); end
    i2c_stop();
    n_checks++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL nack_valid_cnt got=%0d exp=0", valid_cnt); end
    rx_ready = 1'b1;
  endtask

  task automatic test_general_call();
    logic a0, a1;
    logic exp_ack;
    int exp_cnt;
`ifdef GENERAL_CALL_EN
    exp_ack = 1'b1; exp_cnt = 1;
`else
    exp_ack = 1'b0; exp_cnt = 0;
`endif
    clear_mon();
    i2c_start();
    send_byte(8'h00, a0);
    n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL gc_match got=%b exp=0", addr_match); end
    send_byte(8'h55, a1);
    i2c_stop();
    n_checks++; if (a0 !== exp_ack) begin n_fail++; $display("FAIL gc_addr_ack got=%b exp=%b", a0, exp_ack); end
    n_checks++; if (a1 !== exp_ack) begin n_fail++; $display("FAIL gc_data_ack got=%b exp=%b", a1, exp_ack); end
    n_checks++; if (valid_cnt !== exp_cnt) begin n_fail++; $display("FAIL gc_valid_cnt got=%0d exp=%0d", valid_cnt, exp_cnt); end
    if (exp_cnt == 1 && data_q.size() == 1) begin
      n_checks++; if (data_q[0] !== 8'h55) begin n_fail++; $display("FAIL gc_data got=%h exp=55", data_q[0]); end
    end
  endtask

  task automatic test_reset_in_ack();
    clear_mon();
    i2c_start();
    send_bits(8'hA0, 8);
    sda_m = 1'b1; wq();
    n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL rst_ack_pre_oe got=%b exp=1", sda_oe); end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL rst_ack_oe got=%b exp=0", sda_oe); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_ack_busy got=%b exp=0", busy); end
    n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL rst_ack_match got=%b exp=0", addr_match); end
    @(negedge clk);
    reset_n = 1'b1;
    wq();
    i2c_stop();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_wrong_addr();
    test_read_addr();
    test_repeated_start();
    test_partial_and_nack();
    test_general_call();
    test_reset_in_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- I2C target-side write receiver, the responder for the i2cv2 controller.
- Oversamples SCL/SDA with the fast system clock, detects START/STOP, and shifts in and matches the 7-bit address.
- ACKs by driving SDA low (open-drain enable) and delivers received data bytes with a one-cycle valid strobe.
- Sits between the pad-level SCL/SDA nets and a byte-wide consumer (register file or FIFO).

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this block responds to.
- SYNC_STAGES, 2, flip-flop synchronizer depth on i_scl and i_sda (minimum 2).

Ports:
- std_clk  input  1  fast sampling clock, at least 8x SCL frequency.
- reset_n  input  1  synchronous active-low reset.
- i_scl  input  1  SCL pin level (asynchronous).
- i_sda  input  1  SDA pin level (asynchronous).
- i_rx_ready  input  1  consumer can accept a byte; sampled at the data ACK decision.
- o_sda_oe  output  1  1 = pull SDA low; 0 = release.
- o_data  output  8  last received data byte, MSB first on the wire.
- o_data_valid  output  1  one-cycle pulse: o_data updated.
- o_addr_match  output  1  high while this target is addressed for write.
- o_busy  output  1  bus busy: high from START to STOP.

Behaviour:
- Reset (reset_n low at a std_clk edge) values:
  - o_sda_oe=0, o_data=0, o_data_valid=0, o_addr_match=0, o_busy=0.
  - State IDLE, bit counter 0, synchronizers and edge history set to 1.
- Reset mid-transfer releases SDA on the first std_clk edge with reset_n low.
- Input path:
  - SYNC_STAGES flops per line, then one history flop.
  - scl_rise / scl_fall / sda_rise / sda_fall are decoded from history vs current synchronized value.
  - Pin-to-detect latency is SYNC_STAGES+1 cycles.
- START: sda_fall while SCL high in both history and current sample.
- STOP: sda_rise under the same SCL condition.
- If SCL and SDA change in the same sample, only the SCL edge is processed.
- SDA is sampled on scl_rise only.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits on scl_rise (7 address + R/W). At the 8th scl_rise, decide the ACK.
    - Address match and R/W=0 → ack_pending.
    - Otherwise → IGNORE.
  - ADDR_ACK:
    - Entered on the scl_fall following the 8th bit, if ack_pending: o_sda_oe=1, o_addr_match=1.
    - On the next scl_fall: o_sda_oe=0, go to DATA, counter=0.
  - DATA: shift 8 bits on scl_rise. At the scl_fall after the 8th bit:
    - If i_rx_ready=1: o_sda_oe=1, o_data loaded, o_data_valid pulses in that same cycle, go to DATA_ACK.
    - If i_rx_ready=0: no oe (NACK), byte discarded, no valid, go to IGNORE.
  - DATA_ACK: on the next scl_fall: o_sda_oe=0, go to DATA, counter=0.
  - IGNORE: never drives SDA; wait for START or STOP.
- START in any state (repeated START):
  - Go to ADDR, counter=0, o_sda_oe=0, o_addr_match=0.
  - o_busy stays 1.
- STOP in any state, including mid-byte:
  - Go to IDLE, o_sda_oe=0, o_addr_match=0, o_busy=0.
  - A partial byte is discarded with no valid.
- Bit counter is 4 bits and counts 0..8; it never wraps.
- o_busy is set on START regardless of address match.
- The block never stretches SCL. A read address (R/W=1) is NACKed.

Optional Feature:
- Macro GENERAL_CALL_EN.
- Defined: address byte 8'h00 (general call, write) is also ACKed. The following data bytes are received as normal, and o_addr_match is held 0 during a general call.
- Undefined: 8'h00 is treated as a non-matching address and goes to IGNORE.

Test Plan:
- START, 0xA0 (0x50+W), 0xA5, STOP, i_rx_ready=1 → o_sda_oe=1 during both ACK slots; one o_data_valid with o_data=0xA5; o_busy falls after STOP.
- START, 0xA2 (0x51+W), 0x3C, STOP → o_sda_oe never 1; no o_data_valid; o_busy 1→0.
- START, 0xA1 (read) → no ACK; state IGNORE until STOP; o_addr_match stays 0.
- START, 0xA0, 0x12, repeated START, 0xA0, 0x34, STOP → two valids, 0x12 then 0x34; o_busy stays high between the two STARTs.
- START, 0xA0, then STOP after 4 data bits → no valid; o_sda_oe=0; o_busy=0. A later i_rx_ready=0 transfer of 0x77 is NACKed and produces no valid.
- With GENERAL_CALL_EN: START, 0x00, 0x55, STOP → ACK on both bytes; valid with 0x55; o_addr_match=0. Without the macro: no ACK, no valid. Separately, assert reset_n low during an ACK slot → o_sda_oe=0 on the next std_clk edge.
